// File: rtl/irq_priority_encoder.sv
// Registered, parametrised priority encoder for interrupt/event requests.
// Requests are captured into a sticky pending vector (level or rising-edge
// capture), masked, and the highest-index eligible bit is presented on
// idx with a valid flag. An ack while valid clears the presented bit.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - request lines, sampled on clk
//   mask     - per-bit enable (1 = eligible for encoding)
//   ack      - consumer accepts the presented idx (ignored when valid=0)
//   idx      - registered index of highest eligible pending bit
//   valid    - registered; idx refers to an eligible pending request
//   pending  - registered sticky pending vector, unmasked
module irq_priority_encoder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          EDGE_MODE = 1'b0,
    parameter int unsigned IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] mask,
    input  logic             ack,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [WIDTH-1:0] pending
);

    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             valid_q;
    logic             valid_d;

    logic [WIDTH-1:0] set_v;
    logic [WIDTH-1:0] clr_v;
    logic [WIDTH-1:0] elig;

    // Capture, clear, and encode from the next pending state so that a request
    // seen at edge t is presented right after edge t.
    always_comb begin
        set_v     = req;
        clr_v     = '0;
        pending_d = '0;
        elig      = '0;
        valid_d   = 1'b0;
        idx_d     = '0;

        if (EDGE_MODE) begin
            set_v = req & ~req_q;
        end

        for (int unsigned i = 0; i < WIDTH; i++) begin
            clr_v[i] = ack & valid_q & (idx_q == IDX_W'(i));
        end

        // Set is applied after clear so a re-captured bit stays pending.
        pending_d = (pending_q & ~clr_v) | set_v;
        elig      = pending_d & mask;
        valid_d   = |elig;

        // Ascending scan: the last hit is the highest index.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (elig[i]) begin
                idx_d = IDX_W'(i);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
        end
    end

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
- Parametrised, registered successor to the combinational 8-bit priority encoder.
- Latches request bits into a sticky pending register and applies a per-bit enable mask.
- Presents the highest-index enabled pending request with a valid flag. The consumer acknowledges it with a valid/ack handshake, and the ack clears that request.
- Sits between raw event/interrupt sources and a single-threaded service controller.

Parameters:
- WIDTH, 8, number of request lines (>=2); bit WIDTH-1 has the highest priority.
- EDGE_MODE, 0, 0 = level capture (any high req sets pending); 1 = rising-edge capture only.
- IDX_W, $clog2(WIDTH), width of the index output. Derived; do not override.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- req  input  WIDTH  request lines, sampled on clk
- mask  input  WIDTH  per-bit enable (1 = eligible for encoding), sampled on clk
- ack  input  1  consumer accepts the presented index; effective only when valid=1
- idx  output  IDX_W  registered index of the highest eligible pending bit
- valid  output  1  registered; 1 = idx refers to an eligible pending request
- pending  output  WIDTH  registered sticky pending vector, unmasked

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - pending=0, internal req_q=0, idx=0, valid=0.
  - Held while rst_n=0; normal operation resumes on the first clk edge after release.
  - Reset mid-handshake discards all pending requests, including the presented one.
- Capture term set_v:
  - EDGE_MODE=0: set_v = req.
  - EDGE_MODE=1: set_v = req & ~req_q, where req_q is req registered each cycle.
- Clear term clr_v:
  - One-hot of idx when (ack & valid); otherwise 0.
  - ack with valid=0 is ignored.
- Next state: pending_n = (pending & ~clr_v) | set_v.
  - Set wins over clear for the same bit in the same cycle, so that bit stays pending.
- Encode: elig = pending_n & mask.
  - idx/valid are registered from the highest set bit of elig.
  - If elig == 0: valid=0 and idx=0.
  - Unlike the combinational encoder, "no request" is now distinguished from "bit 0" by valid.
- Latency:
  - req high at edge t → pending and valid/idx updated at edge t (registered outputs, visible after t).
  - Exactly 1 cycle from req to valid, with no bubble.
- Handshake:
  - ack is sampled at the edge and applies to the idx visible before that edge.
  - After an acked edge, idx shows the next highest eligible bit, and valid stays 1 if one exists.
  - Back-to-back acks drain one bit per cycle.
- Preemption: idx is recomputed every cycle. A newly captured higher-index bit replaces the presented index before ack, and the lower bit stays pending.
- Mask:
  - Masking a presented bit drops it from idx/valid on the next edge; the pending bit is retained.
  - Unmasking a pending bit makes it eligible on the next edge.
  - Mask never affects capture.
- Level mode: a req held high re-sets its bit every cycle, so an ack cannot clear it while req=1.
- Edge mode: a held req sets the bit once; ack clears it permanently until the next rising edge.
- All req bits set simultaneously: idx = WIDTH-1 (e.g. 7 for WIDTH=8).
- No arithmetic overflow is possible. idx is always < WIDTH.

Test Plan:
- Reset/empty: rst_n=0 asynchronously mid-cycle with pending=8'hA5 → pending=0, valid=0, idx=0 immediately. Release with req=0 → outputs stay 0.
- Priority and latency: WIDTH=8, mask=8'hFF, one-cycle pulse req=8'b0010_0110 at edge t → after t: pending=8'h26, valid=1, idx=5.
- Handshake drain: continuing the pulse scenario, ack=1 for 3 edges → idx sequence 2, 1, then valid=0, pending=0.
- Set-wins/preemption: pending=8'h04 presented (idx=2), same edge ack=1 and req=8'h84 → pending=8'h84, idx=7, valid=1.
- Mask: pending=8'h81, mask=8'h7F → idx=0, valid=1. Then mask=8'h00 → valid=0, pending still 8'h81.
- Edge mode (EDGE_MODE=1): req[3] held high 5 cycles, ack once → pending[3] cleared and not re-set. Drop req[3], raise it again → pending[3]=1, idx=3.
